// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU slice: instruction width,
// default instruction-memory depth and the boot loader state encoding.
package cpu_pkg;

    localparam int INSTR_W           = 32;
    localparam int DEFAULT_MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } loader_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a host byte stream into little-endian instruction words. The word is
// presented combinationally on the byte that completes it (4th byte or last).
module byte_word_packer
    import cpu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               accept_i,
    input  logic [7:0]         data_i,
    input  logic               last_i,
    output logic               word_valid_o,
    output logic [INSTR_W-1:0] word_o
);

    logic [1:0]         lane_q;
    logic [INSTR_W-1:0] acc_q;

    // Lanes above the current one are always zero in acc_q, which gives the
    // zero padding of a short final word for free.
    always_comb begin
        word_o                         = acc_q;
        word_o[{lane_q, 3'b000} +: 8]  = data_i;
        word_valid_o                   = accept_i & ((lane_q == 2'd3) | last_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q <= 2'd0;
            acc_q  <= '0;
        end else if (accept_i) begin
            if (word_valid_o) begin
                lane_q <= 2'd0;
                acc_q  <= '0;
            end else begin
                lane_q <= lane_q + 2'd1;
                acc_q  <= word_o;
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: zeroes instruction memory, loads the host image, then
// releases the CPU and holds start for a fixed number of cycles.
module imem_boot_loader
    import cpu_pkg::*;
#(
    parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
    parameter int ADDR_W     = 8,
    parameter int RUN_CYCLES = 30,
    parameter int CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_data_i,
    input  logic               byte_last_i,
    output logic               byte_ready_o,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic [INSTR_W-1:0] imem_data_o,
    output logic               cpu_rst_n_o,
    output logic               cpu_start_o,
    output logic [ADDR_W:0]    word_count_o,
    output logic [CNT_W-1:0]   run_cycle_o,
    output logic               done_o,
    output logic               err_o,
    output loader_state_e      dbg_state_o
);

    // Byte channel: a byte (with its last flag) transfers on a rising edge
    // where byte_valid_i and byte_ready_o are both high; the host holds data
    // stable while valid is high and ready is low. Ready is registered and
    // never depends combinationally on valid.

    loader_state_e      state_q, state_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic               last_seen_q, last_seen_d;
    logic               ready_q, ready_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic               rst_n_q, rst_n_d;
    logic               start_q, start_d;
    logic [ADDR_W:0]    wc_q, wc_d;
    logic [CNT_W-1:0]   run_q, run_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic               word_valid;
    logic [INSTR_W-1:0] word;

    assign accept = byte_valid_i & ready_q;

    byte_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .accept_i     (accept),
        .data_i       (byte_data_i),
        .last_i       (byte_last_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // All outputs are registered; the comb block computes next-cycle values.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        last_seen_d = last_seen_q;
        ready_d     = 1'b0;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        rst_n_d     = 1'b0;
        start_d     = 1'b0;
        wc_d        = wc_q;
        run_d       = run_q;
        done_d      = done_q;
        err_d       = err_q;

        case (state_q)
            ST_CLEAR: begin
                we_d       = 1'b1;
                addr_d     = clr_addr_q;
                data_d     = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == ADDR_W'(MEM_DEPTH - 1))
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                ready_d = !last_seen_q && !(accept && byte_last_i);
                if (accept && byte_last_i)
                    last_seen_d = 1'b1;
                if (word_valid) begin
                    // A full image drops further words instead of wrapping.
                    if (wc_q == (ADDR_W+1)'(MEM_DEPTH)) begin
                        err_d = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = wc_q[ADDR_W-1:0];
                        data_d = word;
                        wc_d   = wc_q + 1'b1;
                    end
                end
                if (last_seen_q)
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
                rst_n_d = 1'b1;
                start_d = 1'b1;
                run_d   = '0;
            end
            ST_RUN: begin
                rst_n_d = 1'b1;
                if (run_q == CNT_W'(RUN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    run_d   = CNT_W'(RUN_CYCLES);
                end else begin
                    start_d = 1'b1;
                    run_d   = run_q + 1'b1;
                end
            end
            ST_DONE: begin
                rst_n_d = 1'b1;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            last_seen_q <= 1'b0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rst_n_q     <= 1'b0;
            start_q     <= 1'b0;
            wc_q        <= '0;
            run_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            last_seen_q <= last_seen_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rst_n_q     <= rst_n_d;
            start_q     <= start_d;
            wc_q        <= wc_d;
            run_q       <= run_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign cpu_rst_n_o  = rst_n_q;
    assign cpu_start_o  = start_q;
    assign word_count_o = wc_q;
    assign run_cycle_o  = run_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign dbg_state_o  = state_q;

endmodule
